// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down tick counter with IDLE/RUN/PAUSE control and guarded preload.
// Optional registered 7-segment decode output is enabled by defining SEG_DECODE_EN.
module bcd_tick_counter #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    wrap,
  output logic                    load_err
`ifdef SEG_DECODE_EN
  ,
  output logic [7*NUM_DIGITS-1:0] segments
`endif
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] digits_q, digits_d;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;

  logic         load_ok;
  logic [W-1:0] count_nxt;
  logic         count_wrap;
  logic         carry;
  logic [3:0]   nib;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple carry/borrow from digit 0; a carry out of the top digit is a wrap.
  always_comb begin
    count_nxt = digits_q;
    carry     = 1'b1;
    nib       = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = digits_q[4*i +: 4];
      if (carry) begin
        if (!dir) begin
          if (nib == 4'd9) begin
            count_nxt[4*i +: 4] = 4'd0;
          end else begin
            count_nxt[4*i +: 4] = nib + 4'd1;
            carry               = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            count_nxt[4*i +: 4] = 4'd9;
          end else begin
            count_nxt[4*i +: 4] = nib - 4'd1;
            carry               = 1'b0;
          end
        end
      end
    end
    count_wrap = carry;
  end

  // Any control pulse consumes the cycle, so a coincident tick never counts.
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      state_d  = StIdle;
      digits_d = '0;
    end else if (load) begin
      if (state_q != StRun) begin
        if (load_ok) digits_d = load_value;
        else         load_err_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q == StRun) state_d = StPause;
    end else if (start) begin
      state_d = StRun;
    end else if (tick && (state_q == StRun)) begin
      digits_d = count_nxt;
      wrap_d   = count_wrap;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      digits_q   <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign digits   = digits_q;
  assign running  = (state_q == StRun);
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

`ifdef SEG_DECODE_EN
  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [7*NUM_DIGITS-1:0] segments_q, segments_d;

  always_comb begin
    segments_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      segments_d[7*i +: 7] = seg_of(digits_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) segments_q <= '1;
    else       segments_q <= segments_d;
  end

  assign segments = segments_q;
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter: directed scenarios plus a randomized run
// checked against an integer-valued reference model.
module tb_bcd_tick_counter;

  localparam int ND  = 4;
  localparam int MAX = 9999;

  logic          clock = 1'b0;
  logic          reset, tick, start, stop, clear, dir, load;
  logic [15:0]   load_value;
  logic [15:0]   digits;
  logic          running, wrap, load_err;
`ifdef SEG_DECODE_EN
  logic [27:0]   segments;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: count as a plain integer, state as 0=idle 1=run 2=pause.
  int   m_st, m_val;
  logic m_wrap, m_lerr;

  always #10 clock = ~clock;

  bcd_tick_counter #(.NUM_DIGITS(ND)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .dir        (dir),
    .load       (load),
    .load_value (load_value),
    .digits     (digits),
    .running    (running),
    .wrap       (wrap),
    .load_err   (load_err)
`ifdef SEG_DECODE_EN
    ,
    .segments   (segments)
`endif
  );

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_valid(input logic [15:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < ND; i++) if (((b >> (4*i)) & 16'hF) > 16'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * 10 + int'((b >> (4*i)) & 16'hF);
    return v;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_st = 0; m_val = 0; m_wrap = 0; m_lerr = 0;
    end else begin
      m_wrap = 0; m_lerr = 0;
      if (clear) begin
        m_st = 0; m_val = 0;
      end else if (load) begin
        if (m_st != 1) begin
          if (bcd_valid(load_value)) m_val = bcd2int(load_value);
          else m_lerr = 1;
        end
      end else if (stop) begin
        if (m_st == 1) m_st = 2;
      end else if (start) begin
        m_st = 1;
      end else if (tick && m_st == 1) begin
        if (dir) begin
          if (m_val == 0) begin m_val = MAX; m_wrap = 1; end
          else m_val = m_val - 1;
        end else begin
          if (m_val == MAX) begin m_val = 0; m_wrap = 1; end
          else m_val = m_val + 1;
        end
      end
    end
  endtask

  // One clock: drive pulses, advance the model on the edge, sample 1 time unit later.
  task automatic cycle(input logic r, input logic t, input logic st, input logic sp,
                       input logic cl, input logic ld);
    reset = r; tick = t; start = st; stop = sp; clear = cl; load = ld;
    @(posedge clock);
    model_step();
    #1;
    reset = 0; tick = 0; start = 0; stop = 0; clear = 0; load = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: got d=%h run=%b wrap=%b lerr=%b, expected 0000/0/0/0",
               digits, running, wrap, load_err);
    end
`ifdef SEG_DECODE_EN
    checks++;
    if (segments !== '1) begin
      errors++;
      $display("FAIL reset_segments: got %b expected all ones", segments);
    end
`endif
  endtask

  task automatic test_count_pause();
    dir = 0;
    cycle(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (digits !== 16'h0012 || running !== 1'b1) begin
      errors++;
      $display("FAIL count_up12: got d=%h run=%b expected 0012/1", digits, running);
    end
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (digits !== 16'h0012 || running !== 1'b0) begin
      errors++;
      $display("FAIL paused_hold: got d=%h run=%b expected 0012/0", digits, running);
    end
  endtask

  task automatic test_wrap();
    load_value = 16'h9998;
    cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (digits !== 16'h9998 || running !== 1'b0) begin
      errors++;
      $display("FAIL load_pause: got d=%h run=%b expected 9998/0", digits, running);
    end
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (digits !== 16'h9999 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL up_9999: got d=%h wrap=%b expected 9999/0", digits, wrap);
    end
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (digits !== 16'h0000 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap: got d=%h wrap=%b expected 0000/1", digits, wrap);
    end
    dir = 1;
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (digits !== 16'h9999 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got d=%h wrap=%b expected 9999/1", digits, wrap);
    end
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (digits !== 16'h9998 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_9998: got d=%h wrap=%b expected 9998/0", digits, wrap);
    end
    dir = 0;
  endtask

  task automatic test_load_err();
    cycle(0, 0, 0, 0, 1, 0);
    load_value = 16'h12A4;
    cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (digits !== 16'h0000 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL load_bad: got d=%h lerr=%b expected 0000/1", digits, load_err);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err_pulse: got lerr=%b expected 0", load_err);
    end
    cycle(0, 0, 1, 0, 0, 0);
    load_value = 16'h1234;
    cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (digits !== 16'h0000 || load_err !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL load_in_run: got d=%h lerr=%b run=%b expected 0000/0/1",
               digits, load_err, running);
    end
  endtask

  task automatic test_priority();
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0, 0);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle: got run=%b expected 0", running);
    end
    cycle(0, 1, 1, 0, 0, 0);
    checks++;
    if (running !== 1'b1 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL tick_with_start: got d=%h run=%b expected 0000/1", digits, running);
    end
    cycle(0, 0, 0, 0, 1, 0);
    load_value = 16'h0057;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0);
    checks++;
    if (running !== 1'b1 || digits !== 16'h0057) begin
      errors++;
      $display("FAIL run_0057: got d=%h run=%b expected 0057/1", digits, running);
    end
    cycle(0, 1, 0, 0, 1, 0);
    checks++;
    if (running !== 1'b0 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL clear_run: got d=%h run=%b expected 0000/0", digits, running);
    end
  endtask

`ifdef SEG_DECODE_EN
  task automatic test_segments();
    load_value = 16'h0008;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (segments[6:0] !== 7'b0000000 || segments[13:7] !== 7'b1000000) begin
      errors++;
      $display("FAIL seg_0008: got %b_%b expected 1000000_0000000",
               segments[13:7], segments[6:0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] lv;
    cycle(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      dir = 1'($urandom_range(0, 1));
      lv  = int2bcd(int'($urandom_range(0, MAX)));
      if ($urandom_range(0, 3) == 0) lv[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 5) == 0) lv = int2bcd($urandom_range(0, 1) == 0 ? MAX : 0);
      load_value = lv;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0);
      checks++;
      if (digits !== int2bcd(m_val) || running !== (m_st == 1) || wrap !== m_wrap
          || load_err !== m_lerr) begin
        errors++;
        $display("FAIL random[%0d]: got d=%h run=%b wrap=%b lerr=%b, expected %h/%b/%b/%b",
                 n, digits, running, wrap, load_err, int2bcd(m_val), (m_st == 1),
                 m_wrap, m_lerr);
      end
    end
  endtask

  initial begin
    reset = 1; tick = 0; start = 0; stop = 0; clear = 0; dir = 0; load = 0;
    load_value = '0;
    m_st = 0; m_val = 0; m_wrap = 0; m_lerr = 0;
    #3;
    test_reset();
    test_count_pause();
    test_wrap();
    test_load_err();
    test_priority();
`ifdef SEG_DECODE_EN
    test_segments();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
